// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using the double-dabble method.
// Converts one BIN_WIDTH-bit value into BCDdigits*2 packed BCD digits.
// A conversion takes BIN_WIDTH+1 clocks after start is accepted.
// Values that do not fit in the display are shown as all ones, with ovf set.
// Optional feature macro: BIN2BCD_SIGNED_EN. When it is defined, bin_in is
// treated as two's complement, and neg flags negative values.
module bin2bcd_seq #(
  parameter int BCDdigits = 2,
  parameter int BIN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BIN_WIDTH-1:0]     bin_in,
  output logic                     busy,
  output logic                     done,
  output logic [BCDdigits*8-1:0]   bcd_out,
  output logic                     ovf,
  output logic                     neg
);

  localparam int NDIG  = BCDdigits * 2;
  localparam int BCD_W = NDIG * 4;
  localparam int CW    = $clog2(BIN_WIDTH) + 1;
  // Largest value the display can show, 10^NDIG - 1.
  localparam logic [63:0] MAX_VAL = (64'd10 ** NDIG) - 64'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [BCD_W-1:0]     bcd_q;      // BCD accumulator
  logic [BIN_WIDTH-1:0] bin_q;      // binary operand being shifted out
  logic [CW-1:0]        cnt_q;      // shifts already performed
  logic                 ovf_pend_q; // flags latched at capture, published in DONE
  logic                 neg_pend_q;
  logic                 busy_q;
  logic                 done_q;
  logic [BCD_W-1:0]     bcd_out_q;
  logic                 ovf_q;
  logic                 neg_q;

  logic [BIN_WIDTH-1:0] mag_d;
  logic                 neg_d;
  logic                 ovf_d;
  logic [BCD_W-1:0]     adj_d;
  logic [BCD_W-1:0]     bcd_d;
  logic [BIN_WIDTH-1:0] bin_d;

  // Magnitude, sign and overflow of the value that start would capture.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mag_d = bin_in;
    neg_d = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    neg_d = bin_in[BIN_WIDTH-1];
    // The most negative value negates to itself, which is the correct unsigned magnitude.
    if (neg_d) mag_d = ~bin_in + 1'b1;
`endif
    ovf_d = 64'(mag_d) > MAX_VAL;
  end

  // One double-dabble step: add 3 to each nibble >= 5, then shift {BCD, binary} left.
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, bin_d} = {adj_d, bin_q} << 1;
  end

  // Control FSM and all registered outputs. Reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      neg_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_out_q  <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q      <= mag_d;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ovf_d;
            neg_pend_q <= neg_d;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          bcd_out_q <= ovf_pend_q ? '1 : bcd_q;
          ovf_q     <= ovf_pend_q;
          neg_q     <= neg_pend_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;
  assign neg     = neg_q;

endmodule
